// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences an external 1-bit full-adder cell LSB-first.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_ci,
  input  logic             bit_sum,
  input  logic             bit_co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
  logic [WIDTH:0]   shifted;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept, last;

  assign accept   = start && (state != RUN);
  assign last     = (state == RUN) && (cnt == LAST);
  assign shifted  = {bit_sum, acc};
  assign acc_next = WIDTH'(shifted >> 1);

  // Shift registers empty out after WIDTH shifts and carry is cleared at
  // completion, so the cell drives are zero outside RUN with no extra gating.
  assign bit_a  = a_sh[0];
  assign bit_b  = b_sh[0];
  assign bit_ci = carry;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= ci;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      acc  <= acc_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        sum   <= acc_next;
        co    <= bit_co;
        carry <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf   <= carry ^ bit_co;
`endif
      end else begin
        carry <= bit_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8) with a behavioural 1-bit adder cell.
module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ci = 1'b0;
  logic         busy, done, co, bit_a, bit_b, bit_ci, bit_sum, bit_co;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int   total = 0;
  int   passed = 0;
  exp_t q[$];
  logic [W:0] exp_last = '0;

  always #5 clk = ~clk;

  // External full-adder cell
  assign bit_sum = bit_a ^ bit_b ^ bit_ci;
  assign bit_co  = (bit_a & bit_b) | (bit_a & bit_ci) | (bit_b & bit_ci);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co),
    .bit_a(bit_a), .bit_b(bit_b), .bit_ci(bit_ci),
    .bit_sum(bit_sum), .bit_co(bit_co)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("co", 32'(co), 32'(e.c));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.o));
`endif
        $display("result sum=%02h co=%0b expected sum=%02h co=%0b", sum, co, e.s, e.c);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (DUT in DONE),
  // so an immediately following call exercises the back-to-back path.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                        input int ignore_at, input int abort_at);
    exp_t         e;
    logic [W:0]   tot;
    logic [W-1:0] ga, gb, gc, ec;
    int           nbusy, hold_bad, sa, sb, sr, mask;
    bit           seen;
    tot = {1'b0, av} + {1'b0, bv} + (W+1)'(civ);
    sa  = int'($signed(av));
    sb  = int'($signed(bv));
    sr  = sa + sb + int'(civ);
    e.s = tot[W-1:0];
    e.c = tot[W];
    e.o = (sr > 127) || (sr < -128);
    for (int k = 0; k < W; k++) begin
      mask  = (1 << k) - 1;
      ec[k] = 1'(((int'(av) & mask) + (int'(bv) & mask) + int'(civ)) >> k);
    end
    ga = '0; gb = '0; gc = '0;
    start = 1'b1; a = av; b = bv; ci = civ;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    chk("busy_on_accept", 32'(busy), 32'd1);
    nbusy = 0; hold_bad = 0; seen = 0;
    for (int c = 0; c < 4 * W && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1;
      end else if (busy) begin
        if (nbusy < W) begin
          ga[nbusy] = bit_a; gb[nbusy] = bit_b; gc[nbusy] = bit_ci;
        end
        if (sum !== exp_last[W-1:0] || co !== exp_last[W]) hold_bad++;
        if (nbusy == ignore_at) begin
          start = 1'b1; a = 8'h11;
        end
        if (nbusy == abort_at) begin
          rst = 1'b1; #1;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_sum", 32'(sum), 32'd0);
          chk("abort_co", 32'(co), 32'd0);
          $display("abort a=%02h b=%02h at RUN cycle %0d", av, bv, nbusy + 1);
          void'(q.pop_back());
          exp_last = '0;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        nbusy++;
      end else begin
        chk("busy_drop_early", 32'(busy), 32'd1);
      end
    end
    if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(nbusy), 32'(W));
    chk("bit_a_seq", 32'(ga), 32'(av));
    chk("bit_b_seq", 32'(gb), 32'(bv));
    chk("bit_ci_seq", 32'(gc), 32'(ec));
    chk("sum_hold", 32'(hold_bad), 32'd0);
    chk("bits_idle_in_done", 32'({bit_a, bit_b, bit_ci}), 32'd0);
    $display("op a=%02h b=%02h ci=%0b busy=%0d exp sum=%02h co=%0b ovf=%0b",
             av, bv, civ, nbusy, e.s, e.c, e.o);
    exp_last = tot;
  endtask

  initial begin
    idle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_bits", 32'({bit_a, bit_b, bit_ci}), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    idle(2);

    run_op(8'h5A, 8'h3C, 1'b0, -1, -1);
    idle(1);
    chk("done_one_cycle", 32'(done), 32'd0);
    run_op(8'hFF, 8'h01, 1'b0, -1, -1); idle(2);
    run_op(8'hFF, 8'hFF, 1'b1, -1, -1); idle(1);
    run_op(8'h80, 8'h80, 1'b0, -1, -1); idle(1);
    run_op(8'h5A, 8'h3C, 1'b1, 2, -1);  // start at RUN cycle 3 is ignored
    run_op(8'h01, 8'h02, 1'b0, -1, -1); // accepted straight out of DONE
    idle(2);
    run_op(8'hC3, 8'h7E, 1'b1, -1, 3);  // reset at RUN cycle 4
    idle(3);
    run_op(8'h12, 8'h34, 1'b0, -1, -1);
    idle(1);

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : -1, -1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences one external single-bit full-adder cell (the gate/RTL `addbit` datapath) to add two WIDTH-bit operands LSB-first, one bit per clock. It captures operands on a start handshake, drives the adder cell's inputs each cycle, and feeds the carry back through a register. It shifts the sum bits into a result register and pulses `done` when the full word is ready. It sits between a requester holding parallel operands and a shared 1-bit adder instance.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled with an accepted start.
- b  input  WIDTH  operand B; sampled with an accepted start.
- ci  input  1  carry-in; sampled with an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  registered result; held until the next completion.
- co  output  1  registered carry-out; held like `sum`.
- bit_a  output  1  to adder cell input a.
- bit_b  output  1  to adder cell input b.
- bit_ci  output  1  to adder cell input ci.
- bit_sum  input  1  from adder cell output sum; combinational in the same cycle.
- bit_co  input  1  from adder cell output co.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- State machine IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after WIDTH RUN cycles.
  - DONE→RUN on start; DONE→IDLE otherwise.
- Accepted start:
  - a_sh←a, b_sh←b, carry←ci, cnt←0, acc←0.
  - start while in RUN is ignored. No queuing, no error flag.
- Each RUN cycle:
  - Drive bit_a=a_sh[0], bit_b=b_sh[0], bit_ci=carry.
  - At the clock edge: acc←{bit_sum, acc[WIDTH-1:1]}, carry←bit_co, a_sh/b_sh shift right by 1, cnt←cnt+1.
  - cnt is $clog2(WIDTH+1) bits wide and never wraps.
- Completion, at the edge leaving the last RUN cycle (cnt==WIDTH-1):
  - sum←{bit_sum, acc[WIDTH-1:1]}, co←bit_co.
  - State becomes DONE.
- bit_a/bit_b/bit_ci are 0 in IDLE and DONE.
- Result arithmetic: {co,sum} = a + b + ci, modulo 2^(WIDTH+1), unsigned.
- Reset values: state IDLE; busy, done, sum, co, ovf, bit_* all 0; internal registers 0.
- Reset mid-RUN aborts immediately:
  - No done pulse.
  - sum/co go to 0; the previous result is not preserved.

## Timing
- Start accepted at edge t0 → busy=1 during cycles t0..t0+WIDTH−1.
- At edge t0+WIDTH: sum/co/ovf update, done=1 and busy=0 for one cycle.
- Latency from accepted start to done is WIDTH+1 edges including DONE entry; there is no extra bubble.
- Back-to-back: start high during DONE is accepted at the edge leaving DONE. Throughput is one result per WIDTH+1 cycles.
- bit_* outputs are register-driven, glitch-free, and change only at clock edges.
- bit_sum/bit_co must settle within the same cycle (combinational cell).
- sum/co are stable from the DONE edge until the next completion edge, including through the next RUN.

## Configuration
- Macro `SERIAL_ADD_OVF_EN`.
- Defined:
  - Adds output `ovf`, registered at completion as (bit_ci ^ bit_co) of the MSB cycle, i.e. two's-complement overflow of a+b+ci.
  - Held like `sum`; reset 0.
- Undefined:
  - `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x3C, ci=0, start pulse → busy high for 8 cycles, done at edge 8, sum=0x96, co=0, ovf=1.
- a=0xFF, b=0x01, ci=0 → sum=0x00, co=1, ovf=0. a=0xFF, b=0xFF, ci=1 → sum=0xFF, co=1, ovf=0.
- a=0x80, b=0x80, ci=0 → sum=0x00, co=1, ovf=1. Check bit_a/bit_b are 0 for the first 7 RUN cycles and 1 in the 8th.
- Start re-asserted at RUN cycle 3 with a=0x11 → ignored; first result is unchanged.
- Start held through DONE with new operands 0x01+0x02 → accepted with no idle cycle; next done yields sum=0x03, co=0. sum keeps the old value until then.
- rst asserted mid-operation (RUN cycle 4) → busy=0, sum=0, co=0, no done pulse. The next start after reset completes normally.
